// File: rtl/hamming_index_engine.sv
// rtl/hamming_index_engine.sv - pops FIFO words, reports Hamming weight, streams set-bit indices LSB-first
module hamming_index_engine #(
  parameter int DATA_W = 80,
  parameter int IDX_W  = $clog2(DATA_W),
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fifo_emp,
  output logic              o_fifo_rd,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_wt_valid,
  output logic [CNT_W-1:0]  o_wt,
  output logic              o_idx_valid,
  input  logic              i_idx_ready,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_idx_last,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_work_q;
  logic [CNT_W-1:0]  r_wt;
  logic              r_wt_valid;
  logic              r_idx_valid;

  logic [CNT_W-1:0]  w_popcnt;
  logic [IDX_W-1:0]  w_low_idx;
  logic [DATA_W-1:0] w_next_work;
  logic              w_only_one;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_popcnt = w_popcnt + CNT_W'(i_fifo_data[i]);
    end
  end

  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    w_low_idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (r_work_q[i]) begin
        w_low_idx = IDX_W'(i);
      end
    end
  end

  assign w_next_work = r_work_q & (r_work_q - DATA_W'(1));
  assign w_only_one  = (w_next_work == '0);

  assign o_fifo_rd   = (r_state == S_IDLE) && !i_fifo_emp && !i_rst;
  assign o_wt_valid  = r_wt_valid;
  assign o_wt        = r_wt;
  assign o_idx_valid = r_idx_valid;
  assign o_idx       = r_idx_valid ? w_low_idx : '0;
  assign o_idx_last  = r_idx_valid & w_only_one;
  assign o_busy      = (r_state != S_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_work_q    <= '0;
      r_wt        <= '0;
      r_wt_valid  <= 1'b0;
      r_idx_valid <= 1'b0;
    end else begin
      r_wt_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_fifo_emp) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_work_q   <= i_fifo_data;
          r_wt       <= w_popcnt;
          r_wt_valid <= 1'b1;
          if (i_fifo_data != '0) begin
            r_state     <= S_EMIT;
            r_idx_valid <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EMIT: begin
          if (i_idx_ready) begin
            r_work_q <= w_next_work;
            if (w_only_one) begin
              r_state     <= S_IDLE;
              r_idx_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_idx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_index_engine.sv
// tb/tb_hamming_index_engine.sv - directed bench with a word-level reference model for hamming_index_engine
module tb_hamming_index_engine;

  localparam int DATA_W = 80;
  localparam int IDX_W  = 7;
  localparam int CNT_W  = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_emp;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_data;
  logic              wt_valid;
  logic [CNT_W-1:0]  wt;
  logic              idx_valid;
  logic              idx_ready;
  logic [IDX_W-1:0]  idx;
  logic              idx_last;
  logic              busy;

  hamming_index_engine dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_fifo_emp  (fifo_emp),
    .o_fifo_rd   (fifo_rd),
    .i_fifo_data (fifo_data),
    .o_wt_valid  (wt_valid),
    .o_wt        (wt),
    .o_idx_valid (idx_valid),
    .i_idx_ready (idx_ready),
    .o_idx       (idx),
    .o_idx_last  (idx_last),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model and reference model state
  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] popped[$];
  int                exp_idx[$];
  int                acc_log[$];
  int                last_log[$];
  int                wt_log[$];
  int                iv_cnt = 0;
  int                cyc = 0;
  int                rd_cyc = -10;
  bit                saw_rd = 0;

  task automatic push(input logic [DATA_W-1:0] w);
    fq.push_back(w);
    fifo_emp = 1'b0;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    last_log.delete();
    wt_log.delete();
    iv_cnt = 0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (!rst && saw_rd) begin
      if (fq.size() > 0) begin
        fifo_data = fq.pop_front();
        popped.push_back(fifo_data);
      end
    end
    saw_rd = 0;
    fifo_emp = (fq.size() == 0);
  end

  always @(negedge clk) begin
    logic [DATA_W-1:0] w;
    bit exp_wtv;
    bit loading;
    if (rst) begin
      exp_idx.delete();
      popped.delete();
      rd_cyc = -10;
      saw_rd = 0;
    end else begin
      exp_wtv = (cyc == rd_cyc + 2);
      chk("wt_valid", wt_valid, exp_wtv);
      if (exp_wtv) begin
        if (popped.size() == 0) begin
          chk("popped_word_present", 0, 1);
        end else begin
          w = popped.pop_front();
          chk("wt", wt, DATA_W'($countones(w)));
          wt_log.push_back(int'(wt));
          exp_idx.delete();
          for (int i = 0; i < DATA_W; i++) if (w[i]) exp_idx.push_back(i);
        end
      end
      loading = (cyc == rd_cyc + 1);
      chk("busy", busy, loading || exp_idx.size() > 0);
      chk("fifo_rd", fifo_rd, !loading && exp_idx.size() == 0 && !fifo_emp);
      if (fifo_rd) begin
        rd_cyc = cyc;
        saw_rd = 1;
      end
      chk("idx_valid", idx_valid, exp_idx.size() > 0);
      if (idx_valid) iv_cnt++;
      if (exp_idx.size() > 0) begin
        chk("idx", idx, DATA_W'(exp_idx[0]));
        chk("idx_last", idx_last, exp_idx.size() == 1);
        if (idx_valid && idx_ready) begin
          acc_log.push_back(int'(idx));
          last_log.push_back(int'(idx_last));
          void'(exp_idx.pop_front());
        end
      end
    end
    cyc++;
  end

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while ((busy || fq.size() > 0 || popped.size() > 0 || exp_idx.size() > 0) && k < lim);
    if (k >= lim) chk("wait_idle_timeout", 1, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fifo_rd"}, fifo_rd, 0);
    chk({tag, "_wt_valid"}, wt_valid, 0);
    chk({tag, "_wt"}, wt, 0);
    chk({tag, "_idx_valid"}, idx_valid, 0);
    chk({tag, "_idx"}, idx, 0);
    chk({tag, "_idx_last"}, idx_last, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int pat[7];
    int bad;
    int nlast;
    rst = 1'b1;
    idx_ready = 1'b1;
    fifo_data = '0;
    fifo_emp = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // 1: single bit 0
    clear_logs();
    push(80'h1);
    wait_idle(50);
    chk("t1_wt", wt_log.size() == 1 ? wt_log[0] : -1, 1);
    chk("t1_cnt", acc_log.size(), 1);
    if (acc_log.size() == 1) begin
      chk("t1_idx", acc_log[0], 0);
      chk("t1_last", last_log[0], 1);
    end

    // 2: bits 79, 40, 0
    clear_logs();
    push((80'h1 << 79) | (80'h1 << 40) | 80'h1);
    wait_idle(50);
    chk("t2_wt", wt_log.size() == 1 ? wt_log[0] : -1, 3);
    chk("t2_cnt", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk("t2_idx0", acc_log[0], 0);
      chk("t2_idx1", acc_log[1], 40);
      chk("t2_idx2", acc_log[2], 79);
      chk("t2_lasts", {last_log[0][0], last_log[1][0], last_log[2][0]}, 3'b001);
    end

    // 3: all ones
    clear_logs();
    push({DATA_W{1'b1}});
    wait_idle(200);
    chk("t3_wt", wt_log.size() == 1 ? wt_log[0] : -1, 80);
    chk("t3_cnt", acc_log.size(), 80);
    chk("t3_iv_cycles", iv_cnt, 80);
    bad = 0;
    nlast = 0;
    foreach (acc_log[i]) begin
      if (acc_log[i] != i) bad++;
      nlast += last_log[i];
    end
    chk("t3_order", bad, 0);
    chk("t3_nlast", nlast, 1);
    if (last_log.size() == 80) chk("t3_last_on_79", last_log[79], 1);

    // 4: zero word then bit 3
    clear_logs();
    push(80'h0);
    push(80'h8);
    wait_idle(50);
    chk("t4_nwt", wt_log.size(), 2);
    if (wt_log.size() == 2) begin
      chk("t4_wt0", wt_log[0], 0);
      chk("t4_wt1", wt_log[1], 1);
    end
    chk("t4_cnt", acc_log.size(), 1);
    if (acc_log.size() == 1) begin
      chk("t4_idx", acc_log[0], 3);
      chk("t4_last", last_log[0], 1);
    end

    // 5: 0xF0 with backpressure pattern
    clear_logs();
    pat = '{1, 0, 0, 1, 1, 0, 1};
    idx_ready = 1'b0;
    push(80'hF0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      idx_ready = pat[i][0];
      @(posedge clk);
      #1;
    end
    idx_ready = 1'b1;
    wait_idle(50);
    chk("t5_wt", wt_log.size() == 1 ? wt_log[0] : -1, 4);
    chk("t5_cnt", acc_log.size(), 4);
    chk("t5_iv_cycles", iv_cnt, 7);
    if (acc_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t5_idx", acc_log[i], 4 + i);
      chk("t5_lasts", {last_log[0][0], last_log[1][0], last_log[2][0], last_log[3][0]}, 4'b0001);
    end

    // 6: reset after three accepted indices of 0xFF
    clear_logs();
    push(80'hFF);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_pre_idx_valid", idx_valid, 1);
    rst = 1'b1;
    fq.delete();
    fifo_emp = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    chk("t6_cnt", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk("t6_idx0", acc_log[0], 0);
      chk("t6_idx1", acc_log[1], 1);
      chk("t6_idx2", acc_log[2], 2);
      chk("t6_nolast", last_log[0] + last_log[1] + last_log[2], 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_post_rd", fifo_rd, 0);
      chk("t6_post_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
